// File: rtl/err_detect_sampler.sv
// err_detect_sampler
// Speculative capture stage feeding the goML controller. A sample strobe
// captures main-path data, a shadow copy is compared over a fixed window,
// and the outcome is reported dual-rail (err1/err0). On error the final
// shadow value replaces the captured data. The report is held until goML.

module err_detect_sampler #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [WIDTH-1:0] d_main,
    input  logic [WIDTH-1:0] d_shadow,
    input  logic             goML,
    output logic [WIDTH-1:0] q,
    output logic             err1,
    output logic             err0,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt
);

    // Window counter wide enough to hold WINDOW-1; at least one bit so that
    // WINDOW=1 still has a legal (always-zero) counter.
    localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0]  WC_LOAD = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WC_W-1:0]  win_cnt, win_cnt_nxt;
    logic             flag, flag_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             err1_nxt, err0_nxt;
    logic             busy_nxt;
    logic             overrun_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic             mismatch;
    logic             err_now;

    // Next-state and next-output logic for the capture/window/report sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        flag_nxt    = flag;
        q_nxt       = q;
        err1_nxt    = err1;
        err0_nxt    = err0;
        overrun_nxt = overrun;
        err_cnt_nxt = err_cnt;

        // Compare against the captured value, which lives in q until the
        // window closes.
        mismatch = (d_shadow != q);
        err_now  = flag | mismatch;

        case (state)
            ST_IDLE: begin
                // goML carries no meaning here; only a new sample matters.
                if (sample) begin
                    q_nxt       = d_main;
                    win_cnt_nxt = WC_LOAD;
                    flag_nxt    = 1'b0;
                    state_nxt   = ST_WINDOW;
                end
            end

            ST_WINDOW: begin
                // A sample here is dropped but remembered as an overrun.
                if (sample) begin
                    overrun_nxt = 1'b1;
                end
                // Sticky: a mismatch that later clears still counts.
                flag_nxt = err_now;
                if (win_cnt != '0) begin
                    win_cnt_nxt = win_cnt - WC_W'(1);
                end else begin
                    state_nxt = ST_REPORT;
                    err1_nxt  = err_now;
                    err0_nxt  = ~err_now;
                    if (err_now) begin
                        // Substitute the shadow value seen in the last cycle.
                        q_nxt = d_shadow;
                        if (err_cnt != CNT_MAX) begin
                            err_cnt_nxt = err_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            ST_REPORT: begin
                // A sample alongside goML is still dropped: the next capture
                // can only start from IDLE on a later edge.
                if (sample) begin
                    overrun_nxt = 1'b1;
                end
                if (goML) begin
                    err1_nxt  = 1'b0;
                    err0_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                err1_nxt  = 1'b0;
                err0_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            state   <= ST_IDLE;
            win_cnt <= '0;
            flag    <= 1'b0;
            q       <= '0;
            err1    <= 1'b0;
            err0    <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
            flag    <= flag_nxt;
            q       <= q_nxt;
            err1    <= err1_nxt;
            err0    <= err0_nxt;
            busy    <= busy_nxt;
            overrun <= overrun_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_err_detect_sampler.sv
// Testbench for err_detect_sampler. A WINDOW=4 / CNT_W=16 instance covers the
// main scenarios; a WINDOW=1 / CNT_W=2 instance covers the minimum window and
// counter saturation. Expected reports are queued when a sample is driven and
// compared when the DUT presents its report.

module tb_err_detect_sampler;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 16;
    localparam int M_CNT_W = 2;

    typedef struct packed {
        logic             err1;
        logic             err0;
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main instance signals
    logic             sample, goML;
    logic [WIDTH-1:0] d_main, d_shadow, q;
    logic             err1, err0, busy, overrun;
    logic [CNT_W-1:0] err_cnt;

    // Minimum-window instance signals
    logic               m_sample, m_goML;
    logic [WIDTH-1:0]   m_d_main, m_d_shadow, m_q;
    logic               m_err1, m_err0, m_busy, m_overrun;
    logic [M_CNT_W-1:0] m_err_cnt;

    err_detect_sampler #(.WIDTH(WIDTH), .WINDOW(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sample(sample), .d_main(d_main),
        .d_shadow(d_shadow), .goML(goML), .q(q), .err1(err1), .err0(err0),
        .busy(busy), .overrun(overrun), .err_cnt(err_cnt)
    );

    err_detect_sampler #(.WIDTH(WIDTH), .WINDOW(1), .CNT_W(M_CNT_W)) dut_min (
        .clk(clk), .rst(rst), .sample(m_sample), .d_main(m_d_main),
        .d_shadow(m_d_shadow), .goML(m_goML), .q(m_q), .err1(m_err1),
        .err0(m_err0), .busy(m_busy), .overrun(m_overrun), .err_cnt(m_err_cnt)
    );

    exp_t sb[$];
    exp_t m_sb[$];
    exp_t last_exp;
    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;
    logic exp_ovr = 1'b0;

    task automatic test_reset();
        rst = 1'b1;
        sample = 1'b0; goML = 1'b0; d_main = '0; d_shadow = '0;
        m_sample = 1'b0; m_goML = 1'b0; m_d_main = '0; m_d_shadow = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({q, err1, err0, busy, overrun, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_main: got q=%02h err1=%b err0=%b busy=%b ovr=%b cnt=%0d, want all 0",
                     q, err1, err0, busy, overrun, err_cnt);
        end
        checks++;
        if ({m_q, m_err1, m_err0, m_busy, m_overrun, m_err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_min: got q=%02h err1=%b err0=%b busy=%b ovr=%b cnt=%0d, want all 0",
                     m_q, m_err1, m_err0, m_busy, m_overrun, m_err_cnt);
        end
        rst = 1'b0;
        last_exp = '0;
    endtask

    // One WINDOW=4 transaction, starting at a negedge with the DUT idle.
    // ovr_at / goml_at: window cycle (0..3) in which to pulse sample / goML,
    // or -1 for none.
    task automatic run_txn(input logic [WIDTH-1:0] dm,
                           input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                           input logic [WIDTH-1:0] s2, input logic [WIDTH-1:0] s3,
                           input int ovr_at, input int goml_at, input string name);
        logic [WIDTH-1:0] sh [4];
        logic mis;
        exp_t e;
        int   lat;
        sh[0] = s0; sh[1] = s1; sh[2] = s2; sh[3] = s3;
        mis = 1'b0;
        for (int i = 0; i < 4; i++) mis |= (sh[i] != dm);
        if (mis && exp_cnt < 65535) exp_cnt++;
        e.err1 = mis;
        e.err0 = ~mis;
        e.q    = mis ? sh[3] : dm;
        e.cnt  = CNT_W'(exp_cnt);
        sb.push_back(e);
        if (ovr_at >= 0) exp_ovr = 1'b1;

        sample = 1'b1; d_main = dm; d_shadow = dm;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (err1 !== 1'b0 || err0 !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s window%0d: got err1=%b err0=%b busy=%b, want 0 0 1",
                         name, i, err1, err0, busy);
            end
            sample   = (i == ovr_at);
            d_main   = (i == ovr_at) ? ~dm : dm;
            goML     = (i == goml_at);
            d_shadow = sh[i];
        end

        @(negedge clk);
        sample = 1'b0; goML = 1'b0; d_main = dm;
        lat = 1;
        while ((err1 | err0) !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL %s latency: report seen %0d cycle(s) after last window cycle, want 1", name, lat);
        end

        last_exp = sb.pop_front();
        checks++;
        if (err1 !== last_exp.err1 || err0 !== last_exp.err0 ||
            q !== last_exp.q || err_cnt !== last_exp.cnt) begin
            errors++;
            $display("FAIL %s report: got err1=%b err0=%b q=%02h cnt=%0d, want err1=%b err0=%b q=%02h cnt=%0d",
                     name, err1, err0, q, err_cnt,
                     last_exp.err1, last_exp.err0, last_exp.q, last_exp.cnt);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: got %b, want %b", name, overrun, exp_ovr);
        end
    endtask

    // Hold the report for 'hold' cycles, then acknowledge it.
    task automatic ack_report(input int hold, input bit with_sample, input string name);
        for (int i = 0; i < hold; i++) begin
            goML = 1'b0;
            @(negedge clk);
            checks++;
            if (err1 !== last_exp.err1 || err0 !== last_exp.err0 ||
                q !== last_exp.q || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold%0d: got err1=%b err0=%b q=%02h busy=%b, want %b %b %02h 1",
                         name, i, err1, err0, q, busy, last_exp.err1, last_exp.err0, last_exp.q);
            end
        end
        goML = 1'b1;
        if (with_sample) begin
            sample = 1'b1;
            d_main = 8'hC3;
            exp_ovr = 1'b1;
        end
        @(negedge clk);
        goML = 1'b0; sample = 1'b0;
        checks++;
        if (err1 !== 1'b0 || err0 !== 1'b0 || busy !== 1'b0 || q !== last_exp.q) begin
            errors++;
            $display("FAIL %s ack: got err1=%b err0=%b busy=%b q=%02h, want 0 0 0 %02h",
                     name, err1, err0, busy, q, last_exp.q);
        end
        if (with_sample) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || overrun !== 1'b1 || q !== last_exp.q) begin
                errors++;
                $display("FAIL %s dropped_sample: got busy=%b ovr=%b q=%02h, want 0 1 %02h",
                         name, busy, overrun, q, last_exp.q);
            end
        end
    endtask

    task automatic test_clean(input string name);
        run_txn(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, -1, -1, name);
        ack_report(0, 1'b0, name);
    endtask

    task automatic test_late_error();
        // goML during the window must be ignored.
        run_txn(8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5B, -1, 1, "late");
        ack_report(10, 1'b0, "late");
    endtask

    task automatic test_glitch();
        run_txn(8'h5A, 8'h5A, 8'hFF, 8'h5A, 8'h5A, -1, -1, "glitch");
        ack_report(2, 1'b0, "glitch");
    endtask

    task automatic test_overrun();
        run_txn(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h7E, 1, -1, "overrun");
        ack_report(1, 1'b1, "simul");
    endtask

    task automatic test_reset_mid();
        sample = 1'b1; d_main = 8'h33; d_shadow = 8'h33;
        @(negedge clk);
        sample = 1'b0; d_shadow = 8'h34;
        @(negedge clk);
        checks++;
        if (err_cnt !== CNT_W'(exp_cnt) || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got cnt=%0d busy=%b, want cnt=%0d busy=1", err_cnt, busy, exp_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        sb.delete();
        checks++;
        if ({q, err1, err0, busy, overrun, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got q=%02h err1=%b err0=%b busy=%b ovr=%b cnt=%0d, want all 0",
                     q, err1, err0, busy, overrun, err_cnt);
        end
    endtask

    task automatic test_sat_min();
        int tbl [5];
        exp_t e;
        tbl = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            e.err1 = 1'b1;
            e.err0 = 1'b0;
            e.q    = 8'h80 | WIDTH'(k);
            e.cnt  = CNT_W'(tbl[k]);
            m_sb.push_back(e);
            m_sample = 1'b1; m_d_main = 8'h10 + WIDTH'(k); m_d_shadow = m_d_main;
            @(negedge clk);
            m_sample = 1'b0; m_d_shadow = 8'h80 | WIDTH'(k);
            checks++;
            if (m_err1 !== 1'b0 || m_err0 !== 1'b0 || m_busy !== 1'b1) begin
                errors++;
                $display("FAIL min%0d window: got err1=%b err0=%b busy=%b, want 0 0 1",
                         k, m_err1, m_err0, m_busy);
            end
            @(negedge clk);
            e = m_sb.pop_front();
            checks++;
            if (m_err1 !== e.err1 || m_err0 !== e.err0 || m_q !== e.q ||
                m_err_cnt !== e.cnt[M_CNT_W-1:0]) begin
                errors++;
                $display("FAIL min%0d report: got err1=%b err0=%b q=%02h cnt=%0d, want %b %b %02h %0d",
                         k, m_err1, m_err0, m_q, m_err_cnt, e.err1, e.err0, e.q, e.cnt[M_CNT_W-1:0]);
            end
            m_goML = 1'b1;
            @(negedge clk);
            m_goML = 1'b0;
            checks++;
            if (m_err1 !== 1'b0 || m_err0 !== 1'b0 || m_busy !== 1'b0) begin
                errors++;
                $display("FAIL min%0d ack: got err1=%b err0=%b busy=%b, want 0 0 0",
                         k, m_err1, m_err0, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean("clean");
        test_late_error();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_clean("clean_after_rst");
        test_sat_min();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
